// File: rtl/jack_life_ctrl.sv
// Life/invulnerability/game-over controller driven by the Jack/slime contact flag.
// Optional EXTRA_LIFE_EN adds a `bonus` input and LIVES_MAX saturation.
module jack_life_ctrl #(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_FRAMES  = 8,
  parameter logic [9:0]  RESPAWN_X     = 10'd40,
  parameter logic [8:0]  RESPAWN_Y     = 9'd400
`ifdef EXTRA_LIFE_EN
  ,
  parameter int unsigned LIVES_MAX     = 5
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       broken,
  input  logic       frame_tick,
  input  logic       restart,
`ifdef EXTRA_LIFE_EN
  input  logic       bonus,
`endif
  output logic [2:0] lives,
  output logic       hit_pulse,
  output logic       respawn,
  output logic [9:0] respawn_x,
  output logic [8:0] respawn_y,
  output logic       jack_visible,
  output logic       invuln,
  output logic       game_over
);

  typedef enum logic [1:0] {
    StAlive  = 2'b00,
    StInvuln = 2'b01,
    StOver   = 2'b10
  } state_e;

  localparam logic [2:0] LivesInit  = 3'(LIVES_INIT);
  localparam logic [7:0] InvulnInit = 8'(INVULN_FRAMES);
  localparam logic [7:0] BlinkInit  = 8'(BLINK_FRAMES);

  logic       bonus_in;
  logic [2:0] lives_max;
`ifdef EXTRA_LIFE_EN
  assign bonus_in  = bonus;
  assign lives_max = 3'(LIVES_MAX);
`else
  assign bonus_in  = 1'b0;
  assign lives_max = 3'd7;
`endif

  state_e     state_q, state_d;
  logic [2:0] lives_q, lives_d, lives_dec;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       hit_q, hit_d;
  logic       respawn_q, respawn_d;
  logic       visible_q, visible_d;
  logic       invuln_q, over_q;

  assign lives_dec = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    hit_d       = 1'b0;
    respawn_d   = 1'b0;
    visible_d   = visible_q;
    case (state_q)
      StAlive: begin
        visible_d = 1'b1;
        // One grace cycle after a respawn keeps the respawn pulse from repeating back to back.
        if (broken && !respawn_q) begin
          hit_d = 1'b1;
          if (lives_q > 3'd1 || bonus_in) begin
            lives_d     = (bonus_in && lives_dec < lives_max) ? lives_dec + 3'd1 : lives_dec;
            respawn_d   = 1'b1;
            state_d     = StInvuln;
            frame_cnt_d = InvulnInit;
            blink_cnt_d = BlinkInit;
            visible_d   = 1'b0;
          end else begin
            lives_d   = 3'd0;
            state_d   = StOver;
            visible_d = 1'b0;
          end
        end else if (bonus_in && lives_q < lives_max) begin
          lives_d = lives_q + 3'd1;
        end
      end
      StInvuln: begin
        if (bonus_in && lives_q < lives_max) begin
          lives_d = lives_q + 3'd1;
        end
        if (frame_tick) begin
          if (frame_cnt_q <= 8'd1) begin
            state_d     = StAlive;
            frame_cnt_d = 8'd0;
            blink_cnt_d = 8'd0;
            visible_d   = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q - 8'd1;
            if (blink_cnt_q <= 8'd1) begin
              visible_d   = ~visible_q;
              blink_cnt_d = BlinkInit;
            end else begin
              blink_cnt_d = blink_cnt_q - 8'd1;
            end
          end
        end
      end
      StOver: begin
        lives_d   = 3'd0;
        visible_d = 1'b0;
        if (restart) begin
          lives_d   = LivesInit;
          respawn_d = 1'b1;
          visible_d = 1'b1;
          state_d   = StAlive;
        end
      end
      default: begin
        state_d   = StAlive;
        visible_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StAlive;
      lives_q     <= LivesInit;
      frame_cnt_q <= 8'd0;
      blink_cnt_q <= 8'd0;
      hit_q       <= 1'b0;
      respawn_q   <= 1'b0;
      visible_q   <= 1'b1;
      invuln_q    <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      hit_q       <= hit_d;
      respawn_q   <= respawn_d;
      visible_q   <= visible_d;
      invuln_q    <= (state_d == StInvuln);
      over_q      <= (state_d == StOver);
    end
  end

  assign lives        = lives_q;
  assign hit_pulse    = hit_q;
  assign respawn      = respawn_q;
  assign respawn_x    = RESPAWN_X;
  assign respawn_y    = RESPAWN_Y;
  assign jack_visible = visible_q;
  assign invuln       = invuln_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_jack_life_ctrl.sv
// Scoreboard bench for jack_life_ctrl: expected outputs queued at drive time, popped after the edge.
module tb_jack_life_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, broken, frame_tick, restart;
  logic       bonus;
  logic [2:0] lives;
  logic       hit_pulse, respawn, jack_visible, invuln, game_over;
  logic [9:0] respawn_x;
  logic [8:0] respawn_y;

  jack_life_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .broken       (broken),
    .frame_tick   (frame_tick),
    .restart      (restart),
`ifdef EXTRA_LIFE_EN
    .bonus        (bonus),
`endif
    .lives        (lives),
    .hit_pulse    (hit_pulse),
    .respawn      (respawn),
    .respawn_x    (respawn_x),
    .respawn_y    (respawn_y),
    .jack_visible (jack_visible),
    .invuln       (invuln),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  // Field order: lives, hit_pulse, respawn, jack_visible, invuln, game_over.
  typedef struct packed {
    logic [2:0] lv;
    logic       hit;
    logic       rsp;
    logic       vis;
    logic       inv;
    logic       ovr;
  } obs_t;

  obs_t exp_q[$];
  obs_t got, want;
  int   checks = 0;
  int   failures = 0;

  function automatic obs_t mk(int lv, bit hit, bit rsp, bit vis, bit inv, bit ovr);
    return '{lv: 3'(lv), hit: hit, rsp: rsp, vis: vis, inv: inv, ovr: ovr};
  endfunction

  function automatic obs_t sample();
    return '{lv: lives, hit: hit_pulse, rsp: respawn, vis: jack_visible, inv: invuln,
             ovr: game_over};
  endfunction

  // Clocks n edges with frame_tick held high, no checking.
  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    exp_q.push_back(mk(3, 0, 0, 1, 0, 0));
    @(posedge clk); #1;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL reset got=%b want=%b", got, want);
    end
    checks++;
    if (respawn_x !== 10'd40 || respawn_y !== 9'd400) begin
      failures++; $display("FAIL respawn_xy got=%0d,%0d want=40,400", respawn_x, respawn_y);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      exp_q.push_back(mk(3, 0, 0, 1, 0, 0));
      @(posedge clk); #1;
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL idle cycle %0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_hit();
    broken = 1'b1;
    exp_q.push_back(mk(2, 1, 1, 0, 1, 0));
    @(posedge clk); #1;
    broken = 1'b0;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL first_hit got=%b want=%b", got, want);
    end
    exp_q.push_back(mk(2, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL pulse_drop got=%b want=%b", got, want);
    end
  endtask

  task automatic test_invuln_blink();
    broken = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      frame_tick = 1'b1;
      if (k < 120) exp_q.push_back(mk(2, 0, 0, ((k / 8) % 2) == 1, 1, 0));
      else         exp_q.push_back(mk(2, 0, 0, 1, 0, 0));
      @(posedge clk); #1;
      frame_tick = 1'b0;
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL blink tick %0d got=%b want=%b", k, got, want);
      end
      if (k < 120) begin
        exp_q.push_back(want);
        @(posedge clk); #1;
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          failures++; $display("FAIL blink hold %0d got=%b want=%b", k, got, want);
        end
      end
    end
    exp_q.push_back(mk(1, 1, 1, 0, 1, 0));
    @(posedge clk); #1;
    broken = 1'b0;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL rehit got=%b want=%b", got, want);
    end
  endtask

  task automatic test_game_over();
    ticks(120);
    exp_q.push_back(mk(1, 0, 0, 1, 0, 0));
    @(posedge clk); #1;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL alive_one got=%b want=%b", got, want);
    end
    broken = 1'b1;
    exp_q.push_back(mk(0, 1, 0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL over step %0d got=%b want=%b", i, got, want);
      end
    end
    broken = 1'b0;
    restart = 1'b1;
    exp_q.push_back(mk(3, 0, 1, 1, 0, 0));
    @(posedge clk); #1;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL restart got=%b want=%b", got, want);
    end
    // restart while alive must do nothing
    exp_q.push_back(mk(3, 0, 0, 1, 0, 0));
    @(posedge clk); #1;
    restart = 1'b0;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL restart_alive got=%b want=%b", got, want);
    end
  endtask

  task automatic test_reset_mid_invuln();
    broken = 1'b1;
    @(posedge clk); #1;
    broken = 1'b0;
    ticks(50);
    exp_q.push_back(mk(2, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL invuln_50 got=%b want=%b", got, want);
    end
    rst_n = 1'b0;
    exp_q.push_back(mk(3, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(3, 0, 0, 1, 0, 0));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL reset_invuln %0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Three hits separated by full back-to-back tick runs end in OVER.
    for (int i = 0; i < 3; i++) begin
      broken = 1'b1;
      @(posedge clk); #1;
      broken = 1'b0;
      ticks(120);
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
    @(posedge clk); #1;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL b2b_over got=%b want=%b", got, want);
    end
    rst_n = 1'b0;
    exp_q.push_back(mk(3, 0, 0, 1, 0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL reset_over got=%b want=%b", got, want);
    end
  endtask

`ifdef EXTRA_LIFE_EN
  task automatic test_extra_life();
    bonus = 1'b1;
    exp_q.push_back(mk(4, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(5, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(5, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL bonus_sat %0d got=%b want=%b", i, got, want);
      end
    end
    bonus = 1'b0;
    for (int i = 0; i < 4; i++) begin
      broken = 1'b1;
      @(posedge clk); #1;
      broken = 1'b0;
      ticks(120);
    end
    broken = 1'b1;
    bonus  = 1'b1;
    exp_q.push_back(mk(1, 1, 1, 0, 1, 0));
    @(posedge clk); #1;
    broken = 1'b0;
    bonus  = 1'b0;
    got = sample(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL bonus_hit got=%b want=%b", got, want);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; broken = 1'b0; frame_tick = 1'b0; restart = 1'b0; bonus = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_hit();
    test_invuln_blink();
    test_game_over();
    test_reset_mid_invuln();
    test_back_to_back();
`ifdef EXTRA_LIFE_EN
    test_extra_life();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jack_life_ctrl.md
Name: jack_life_ctrl

Overview:
- Consumes the level-type `broken` flag from the Jack/slime contact detector. Turns it into game consequences: life count, an invulnerability window with sprite blink, a respawn request and the game-over state.
- Sits between the collision logic and the Jack movement/render blocks. Runs on the pixel/system clock, with a one-cycle frame tick for timing.

Parameters:
- LIVES_INIT, 3, lives loaded at reset and on restart (1..7).
- INVULN_FRAMES, 120, frame ticks of invulnerability after a non-fatal hit (1..255).
- BLINK_FRAMES, 8, frame ticks per sprite visibility toggle during invulnerability (1..INVULN_FRAMES).
- RESPAWN_X, 10'd40, respawn x coordinate (pixels).
- RESPAWN_Y, 9'd400, respawn y coordinate (pixels).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- broken  in  1  level: Jack touching an unfrozen slime.
- frame_tick  in  1  one-cycle pulse per video frame.
- restart  in  1  one-cycle pulse; honoured only in OVER.
- lives  out  3  remaining lives.
- hit_pulse  out  1  one-cycle pulse on every accepted hit.
- respawn  out  1  one-cycle pulse; movement block loads respawn_x/respawn_y.
- respawn_x  out  10  constant RESPAWN_X.
- respawn_y  out  9  constant RESPAWN_Y.
- jack_visible  out  1  sprite enable for the renderer.
- invuln  out  1  high while in INVULN.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=ALIVE, lives=LIVES_INIT, frame counter=0, blink counter=0.
  - hit_pulse=0, respawn=0, jack_visible=1, invuln=0, game_over=0.
  - Reset mid-INVULN or mid-OVER aborts immediately. No pulse is emitted on reset.
- All outputs are registered. Response latency is 1 clock from the sampled input.
- State ALIVE:
  - broken=1 with lives>1: next cycle lives=lives-1, hit_pulse=1, respawn=1, state=INVULN, counter=INVULN_FRAMES, blink counter=BLINK_FRAMES, jack_visible=0.
  - broken=1 with lives==1: next cycle lives=0, hit_pulse=1, respawn=0, state=OVER.
  - `broken` is treated as a level. There is no edge detect, so continued contact after invulnerability ends is a new hit.
- State INVULN:
  - `broken` is ignored and invuln=1.
  - Each frame_tick decrements the counter and the blink counter.
  - When the blink counter reaches 0: toggle jack_visible and reload BLINK_FRAMES.
  - On the frame_tick where the counter goes 1→0: state=ALIVE, jack_visible=1, invuln=0 in the same update.
  - If frame_tick and broken coincide on the exit cycle, broken is ignored and is evaluated from the next cycle in ALIVE.
- State OVER:
  - game_over=1, jack_visible=0, lives=0, `broken` ignored.
  - restart=1: next cycle lives=LIVES_INIT, respawn=1, jack_visible=1, game_over=0, state=ALIVE.
  - restart outside OVER has no effect.
- Pulse rules: hit_pulse and respawn are high for exactly one cycle each time and never stay high two consecutive cycles.
- Width rules:
  - lives is 3-bit unsigned and never underflows; decrement happens only when lives≥1.
  - Frame counter is 8-bit. Blink counter is 8-bit.
- Unused state encodings recover to ALIVE on the next clock.

Optional Feature:
- Macro EXTRA_LIFE_EN.
- When defined:
  - Adds input `bonus` (1 bit, one-cycle pulse, e.g. from a collected item) and parameter LIVES_MAX (default 5).
  - `bonus` in ALIVE or INVULN increments lives, saturating at LIVES_MAX. It is ignored in OVER.
  - If bonus and an accepted hit occur in the same cycle, the hit is applied first using the current lives, then the bonus: net lives unchanged, no game over, hit_pulse=1, and the block enters INVULN even when lives==1.
- When not defined: no `bonus` port and no LIVES_MAX. lives changes only by hit, reset and restart.

Test Plan:
1. Reset, then hold broken=0 for 1000 cycles → lives=3, jack_visible=1, hit_pulse/respawn/game_over never asserted.
2. ALIVE, lives=3, raise broken for 1 cycle → next cycle lives=2, hit_pulse=1, respawn=1, invuln=1, jack_visible=0; both pulses low on the following cycle.
3. After the hit, hold broken=1 and supply 120 frame_ticks (INVULN_FRAMES=120, BLINK_FRAMES=8) → lives stays 2 and jack_visible toggles every 8 ticks. On the 120th tick invuln=0 and jack_visible=1; one cycle later lives=1 and hit_pulse=1 again.
4. lives=1, broken=1 → lives=0, game_over=1, respawn stays 0. Then restart pulse → next cycle lives=3, respawn=1, game_over=0, jack_visible=1.
5. In INVULN after 50 ticks, drive rst_n=0 for 1 cycle → lives=3, invuln=0, jack_visible=1, no pulses.
6. (EXTRA_LIFE_EN) lives=5 with bonus → stays 5. lives=1 with bonus and broken in the same cycle → lives=1, hit_pulse=1, state INVULN, game_over=0.
